uart_rx: RTL and testbench

// - Serial receiver paired with uart_tx, consuming its line output. Frame, LSB first:

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing constants and receiver state encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } rx_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Even parity bit for a data byte (the value the transmitter appends).
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Flop chain that brings the asynchronous serial line into the clk_t domain.
// Resets to the idle level so a reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_t,
  input  logic srst_n,
  input  logic d_in,
  output logic q_out
);

  if (STAGES == 0) begin : g_bypass
    assign q_out = d_in;
  end else begin : g_chain
    logic [STAGES-1:0] chain;

    // Shift the line through STAGES flops, idle-high on reset.
    always_ff @(posedge clk_t) begin
      if (!srst_n) begin
        chain <= {STAGES{IDLE_LVL}};
      end else begin
        chain[0] <= d_in;
        for (int i = 1; i < STAGES; i++) begin
          chain[i] <= chain[i-1];
        end
      end
    end

    assign q_out = chain[STAGES-1];
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start / 8 data bits LSB first / optional even parity / stop.
// Recovered byte and status sit in a holding register offered downstream.
//
// Handshake: data_valid rises when a frame is loaded and stays high, with
// data_out/parity_err/frame_err stable, until the cycle where data_valid and
// data_ready are both high; data_valid drops on the following cycle unless a
// new frame loads in that same cycle, in which case the new byte replaces it.
// A frame finishing while the register is still full and not being accepted
// is dropped and reported by a one-cycle overrun pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk_t,
  input  logic       srst_n,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output rx_state_e  state_dbg
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] HALF = BW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

  rx_state_e            state;
  logic [BW-1:0]        baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 rx_s;
  logic                 at_half;
  logic                 at_end;
  logic [BW-1:0]        next_baud;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_t  (clk_t),
    .srst_n (srst_n),
    .d_in   (rx_in),
    .q_out  (rx_s)
  );

  // Bit timing decodes: mid-bit sample point and end-of-bit wrap.
  always_comb begin
    at_half   = (baud_cnt == HALF);
    at_end    = (baud_cnt == LAST);
    next_baud = at_end ? '0 : baud_cnt + BW'(1);
  end

  // Frame FSM, bit counters and the downstream holding register.
  always_ff @(posedge clk_t) begin
    if (!srst_n) begin
      state      <= ARM;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        // Refuse to start until the line has been seen idle at least once.
        ARM: begin
          baud_cnt <= '0;
          if (rx_s == IDLE_LVL) state <= IDLE;
        end

        // The first low cycle is cycle 0 of the start bit.
        IDLE: begin
          baud_cnt <= '0;
          perr     <= 1'b0;
          if (rx_s == START_BIT) begin
            if (CLKS_PER_BIT == 1) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state    <= START;
              baud_cnt <= BW'(1);
            end
          end
        end

        // A start bit that is high again at mid-bit was only a glitch.
        START: begin
          if (at_half && rx_s == IDLE_LVL) begin
            state    <= IDLE;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= next_baud;
            if (at_end) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end

        DATA: begin
          baud_cnt <= next_baud;
          if (at_half) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          if (at_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end

        PARITY: begin
          baud_cnt <= next_baud;
          if (at_half) perr <= ^{shreg, rx_s};
          if (at_end) state <= STOP;
        end

        // Completes at mid-stop so a following start bit is never missed.
        STOP: begin
          if (at_half) begin
            baud_cnt <= '0;
            if (data_valid && !data_ready) begin
              overrun <= 1'b1;
            end else begin
              data_out   <= shreg;
              parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
              frame_err  <= (rx_s != STOP_BIT);
              data_valid <= 1'b1;
            end
            state <= (rx_s == IDLE_LVL) ? IDLE : ARM;
          end else begin
            baud_cnt <= next_baud;
          end
        end

        default: state <= ARM;
      endcase
    end
  end

  assign busy      = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a fast instance (1 clk/bit, no synchroniser) and a
// slow instance (16 clk/bit, 2-flop synchroniser) driven by a frame task
// that behaves like uart_tx. Accepted bytes are checked against a queue.
module tb_uart_rx;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_t = 1'b0;
  always #5 clk_t = ~clk_t;

  logic srst_n;
  int   cyc = 0;
  always @(posedge clk_t) cyc++;

  // ---------------- DUT signals ----------------
  logic       rx_fl, rdy_f, dv_f, pe_f, fe_f, ov_f, busy_f;
  logic [7:0] do_f;
  rx_state_e  st_f;
  logic       rx_sl, rdy_s, dv_s, pe_s, fe_s, ov_s, busy_s;
  logic [7:0] do_s;
  rx_state_e  st_s;

  uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(0), .PARITY_EN(1)) dut_fast (
    .clk_t(clk_t), .srst_n(srst_n), .rx_in(rx_fl),
    .data_out(do_f), .data_valid(dv_f), .data_ready(rdy_f),
    .parity_err(pe_f), .frame_err(fe_f), .overrun(ov_f),
    .busy(busy_f), .state_dbg(st_f)
  );

  uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2), .PARITY_EN(1)) dut_slow (
    .clk_t(clk_t), .srst_n(srst_n), .rx_in(rx_sl),
    .data_out(do_s), .data_valid(dv_s), .data_ready(rdy_s),
    .parity_err(pe_s), .frame_err(fe_s), .overrun(ov_s),
    .busy(busy_s), .state_dbg(st_s)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry layout: {parity_err, frame_err, data[7:0]}
  logic [9:0] exp_q_f[$];
  logic [9:0] exp_q_s[$];
  int         ovr_f = 0;
  int         ovr_s = 0;
  int         rise_f = 0;
  logic       prev_v_f = 1'b0;

  always @(negedge clk_t) begin
    if (ov_f === 1'b1) ovr_f++;
    if (ov_s === 1'b1) ovr_s++;
    // Edge at which the new data_valid is first sampled.
    if (dv_f === 1'b1 && !prev_v_f) rise_f = cyc + 1;
    prev_v_f = (dv_f === 1'b1);
    if (dv_f === 1'b1 && rdy_f === 1'b1) begin
      if (exp_q_f.size() == 0) check_eq("fast_spurious_valid", 32'(dv_f), 32'd0);
      else check_eq("fast_rx", 32'({pe_f, fe_f, do_f}), 32'(exp_q_f.pop_front()));
    end
    if (dv_s === 1'b1 && rdy_s === 1'b1) begin
      if (exp_q_s.size() == 0) check_eq("slow_spurious_valid", 32'(dv_s), 32'd0);
      else check_eq("slow_rx", 32'({pe_s, fe_s, do_s}), 32'(exp_q_s.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_line(input bit sel, input logic b);
    if (sel) rx_sl = b;
    else     rx_fl = b;
  endtask

  // Called #1 after a posedge; returns #1 after the posedge ending the stop bit.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_inv, input logic stop_v);
    int          cpb;
    logic [10:0] bits;
    cpb  = sel ? 16 : 1;
    bits = {stop_v, even_parity(d) ^ par_inv, d, START_BIT};
    for (int i = 0; i < 11; i++) begin
      set_line(sel, bits[i]);
      repeat (cpb) @(posedge clk_t);
      #1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_t);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t_start;
    int ovr_save;
    logic [7:0] d5a;

    srst_n = 1'b0;
    rx_fl  = IDLE_LVL;
    rx_sl  = IDLE_LVL;
    rdy_f  = 1'b1;
    rdy_s  = 1'b1;
    wait_cycles(3);

    // Reset state
    check_eq("rst_data_out", 32'(do_f), 32'h0);
    check_eq("rst_valid", 32'(dv_f), 32'd0);
    check_eq("rst_flags", 32'({pe_f, fe_f, ov_f}), 32'd0);
    check_eq("rst_busy", 32'(busy_f), 32'd0);
    check_eq("rst_state_fast", 32'(st_f), 32'(ARM));
    check_eq("rst_state_slow", 32'(st_s), 32'(ARM));

    srst_n = 1'b1;
    wait_cycles(4);
    check_eq("arm_to_idle", 32'(st_f), 32'(IDLE));

    // 0xA5, latency: start sampled at edge T, data_valid sampled high at T+11
    exp_q_f.push_back({2'b00, 8'hA5});
    t_start = cyc + 1;
    send_frame(0, 8'hA5, 0, STOP_BIT);
    check_eq("a5_valid_after_stop", 32'(dv_f), 32'd1);
    wait_cycles(2);
    check_eq("a5_latency", 32'(rise_f - t_start), 32'd11);

    // Inverted parity on 0x3C
    exp_q_f.push_back({2'b10, 8'h3C});
    send_frame(0, 8'h3C, 1, STOP_BIT);
    wait_cycles(3);

    // Line held low from the stop bit: frame error, parks in ARM
    exp_q_f.push_back({2'b01, 8'h00});
    send_frame(0, 8'h00, 0, 1'b0);
    check_eq("stuck_low_state", 32'(st_f), 32'(ARM));
    wait_cycles(20);
    check_eq("stuck_low_still_arm", 32'(st_f), 32'(ARM));
    check_eq("stuck_low_no_busy", 32'(busy_f), 32'd0);
    rx_fl = IDLE_LVL;
    wait_cycles(1);
    exp_q_f.push_back({2'b00, 8'h42});
    send_frame(0, 8'h42, 0, STOP_BIT);
    wait_cycles(3);

    // Overrun: hold 0x11, 0x22 is dropped
    ovr_f = 0;
    rdy_f = 1'b0;
    exp_q_f.push_back({2'b00, 8'h11});
    send_frame(0, 8'h11, 0, STOP_BIT);
    send_frame(0, 8'h22, 0, STOP_BIT);
    wait_cycles(2);
    check_eq("ovr_pulses", 32'(ovr_f), 32'd1);
    check_eq("ovr_held_byte", 32'(do_f), 32'h11);
    check_eq("ovr_held_valid", 32'(dv_f), 32'd1);
    rdy_f = 1'b1;
    wait_cycles(3);
    check_eq("ovr_second_lost", 32'(dv_f), 32'd0);
    check_eq("ovr_pulses_after", 32'(ovr_f), 32'd1);

    // Reset while receiving data bit 4
    d5a = 8'h5A;
    rx_fl = START_BIT;
    wait_cycles(1);
    for (int i = 0; i < 4; i++) begin
      rx_fl = d5a[i];
      wait_cycles(1);
    end
    rx_fl = d5a[4];
    check_eq("mid_frame_busy", 32'(busy_f), 32'd1);
    check_eq("mid_frame_state", 32'(st_f), 32'(DATA));
    srst_n = 1'b0;
    wait_cycles(1);
    srst_n = 1'b1;
    rx_fl  = IDLE_LVL;
    check_eq("mid_rst_state", 32'(st_f), 32'(ARM));
    check_eq("mid_rst_valid", 32'(dv_f), 32'd0);
    wait_cycles(3);
    exp_q_f.push_back({2'b00, 8'h5A});
    send_frame(0, 8'h5A, 0, STOP_BIT);
    wait_cycles(3);

    // Back-to-back 0xFF, 0x00, accepting one cycle before each stop
    ovr_save = ovr_f;
    rdy_f = 1'b0;
    exp_q_f.push_back({2'b00, 8'hFF});
    exp_q_f.push_back({2'b00, 8'h00});
    send_frame(0, 8'hFF, 0, STOP_BIT);
    fork
      send_frame(0, 8'h00, 0, STOP_BIT);
      begin
        wait_cycles(9);
        rdy_f = 1'b1;
        wait_cycles(1);
        rdy_f = 1'b0;
      end
    join
    rdy_f = 1'b1;
    wait_cycles(3);
    check_eq("b2b_no_overrun", 32'(ovr_f - ovr_save), 32'd0);

    // Slow instance: 5-cycle glitch on the idle line
    rx_sl = START_BIT;
    wait_cycles(5);
    rx_sl = IDLE_LVL;
    wait_cycles(30);
    check_eq("glitch_state", 32'(st_s), 32'(IDLE));
    check_eq("glitch_no_valid", 32'(dv_s), 32'd0);
    exp_q_s.push_back({2'b00, 8'h81});
    send_frame(1, 8'h81, 0, STOP_BIT);
    rx_sl = IDLE_LVL;
    wait_cycles(30);

    // Drain: every expected byte must have been delivered
    for (int i = 0; i < 200 && (exp_q_f.size() + exp_q_s.size()) != 0; i++) begin
      @(posedge clk_t);
    end
    #1;
    check_eq("queues_drained", 32'(exp_q_f.size() + exp_q_s.size()), 32'd0);
    check_eq("slow_overrun_none", 32'(ovr_s), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
